apb4_requester: RTL and testbench
=================================

// Module: apb4_requester
// PURPOSE
//  APB4 requester (master) bridge. Converts a valid/ready request channel from
//  the core/system interconnect into single APB4 transfers to peripherals
//  (UART, timers, GPIO) and returns the result on a valid/ready response channel.
//  One transfer is outstanding at a time. A bounded wait timeout guards against
//  slaves that hang.
// PARAMETERS
//  ADDR_WIDTH      32   PADDR / req_addr_i width
//  DATA_WIDTH      32   PWDATA/PRDATA width; PSTRB width = DATA_WIDTH/8
//  TIMEOUT_CYCLES  256  max ACCESS cycles without PREADY; 0 = timeout disabled
// PORTS
//  PCLK         in   1           clock, all logic on rising edge
//  PRESET       in   1           synchronous active-high reset
//  req_valid_i  in   1           request valid
//  req_ready_o  out  1           request accepted when valid&ready
//  req_addr_i   in   ADDR_WIDTH  byte address, passed to PADDR unaltered
//  req_write_i  in   1           1=write, 0=read
//  req_wdata_i  in   DATA_WIDTH  write data
//  req_strb_i   in   DATA_WIDTH/8 write byte strobes
//  req_prot_i   in   3           PPROT value
//  rsp_valid_o  out  1           response valid
//  rsp_ready_i  in   1           response consumed when valid&ready
//  rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes and timeouts)
//  rsp_err_o    out  1           PSLVERR or timeout
//  rsp_tmo_o    out  1           response was a timeout
//  PSEL,PENABLE,PWRITE out 1     APB4 controls
//  PADDR        out  ADDR_WIDTH; PWDATA out DATA_WIDTH; PSTRB out DATA_WIDTH/8; PPROT out 3
//  PREADY,PSLVERR in 1; PRDATA in DATA_WIDTH   APB4 slave returns
// BEHAVIOUR
//  - FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All APB outputs registered.
//  - Reset (PRESET=1 at edge): state IDLE; PSEL=PENABLE=PWRITE=0; PADDR, PWDATA,
//    PSTRB, PPROT=0; rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=rsp_tmo_o=0.
//    req_ready_o = (state==IDLE) & ~PRESET.
//  - IDLE: req_ready_o=1. On req_valid_i, latch the request and go to SETUP.
//    PADDR/PWRITE/PWDATA/PPROT are loaded. PSTRB = req_strb_i for writes and
//    forced 0 for reads.
//  - SETUP (1 cycle): PSEL=1, PENABLE=0. Then ACCESS.
//  - ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA/PSTRB/PPROT are stable from
//    SETUP to the end of ACCESS.
//    On PREADY=1: capture PRDATA (reads only; writes give 0) and PSLVERR into
//    rsp_err_o. Drop PSEL/PENABLE next cycle and go to RESP.
//  - Timeout: wait counter is $clog2(TIMEOUT_CYCLES+1) bits. It is cleared on
//    entry to ACCESS and increments each ACCESS cycle with PREADY=0.
//    On the ACCESS cycle where count==TIMEOUT_CYCLES-1 and PREADY=0: abort, drop
//    PSEL/PENABLE, rsp_err_o=1, rsp_tmo_o=1, rsp_rdata_o=0, go to RESP.
//    If PREADY=1 on that same cycle, it is a normal completion (PREADY wins).
//    TIMEOUT_CYCLES=0 means wait forever.
//  - RESP: rsp_valid_o=1. rsp_* are held stable until rsp_ready_i=1, then IDLE.
//    No new request is accepted in RESP. req_ready_o=0 in SETUP/ACCESS/RESP.
//  - Latency with zero-wait slave and rsp_ready_i=1: accept at cycle 0; PSEL
//    rises at cycle 1; PENABLE at cycle 2; rsp_valid_o at cycle 3; back to IDLE
//    at cycle 4. Peak throughput is 1 transfer / 4 cycles. Each slave wait state
//    adds 1 cycle.
//  - Outside SETUP/ACCESS: PSEL=PENABLE=0. PADDR/PWDATA/PSTRB hold their last
//    values (no toggling).
//  - Reset mid-transfer: the transfer is abandoned. PSEL/PENABLE are 0 after the
//    edge and no response is ever issued for it.
// TESTING
//  1 Write addr 0x0C, wdata 0x83, strb 4'b0001, PREADY=1 -> PSEL at c1, PENABLE
//    at c2, PWRITE=1, PWDATA=0x83, PSTRB=0001; rsp_valid at c3, err=0.
//  2 Read addr 0x14, slave holds PREADY=0 for 3 ACCESS cycles, PRDATA=0x60 ->
//    ACCESS lasts 4 cycles, PSTRB=0, rsp_rdata_o=0x60, err=0.
//  3 Write with PSLVERR=1 in the PREADY cycle -> rsp_err_o=1, rsp_tmo_o=0,
//    rsp_rdata_o=0.
//  4 TIMEOUT_CYCLES=8, PREADY never set -> PSEL drops after 8 ACCESS cycles;
//    err=1, tmo=1, rdata=0. Repeat with PREADY=1 on the 8th cycle -> normal
//    completion, tmo=0.
//  5 rsp_ready_i held 0 for 5 cycles after rsp_valid_o, req_valid_i=1 ->
//    rsp_* stable, req_ready_o=0, no PSEL; next request's PSEL 2 cycles after
//    the response handshake.
//  6 Assert PRESET during ACCESS -> next cycle PSEL=PENABLE=0, rsp_valid_o=0;
//    req_ready_o=1 the cycle after PRESET deasserts.

Source files
------------

// File: rtl/apb4_requester.sv
// APB4 requester bridge: turns valid/ready requests into single APB4 transfers
// and returns data/error on a valid/ready response channel, with a wait timeout.
module apb4_requester #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic                    req_write_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] req_strb_i,
   input  logic [2:0]              req_prot_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    rsp_tmo_o,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [2:0]              PPROT,
   input  logic                    PREADY,
   input  logic                    PSLVERR,
   input  logic [DATA_WIDTH-1:0]   PRDATA
);

   localparam int STRB_W = DATA_WIDTH / 8;
   // A zero timeout still needs a 1-bit counter to keep the declarations legal.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_e;

   state_e                state_q, state_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [STRB_W-1:0]     pstrb_q, pstrb_d;
   logic [2:0]            pprot_q, pprot_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  rsp_tmo_q, rsp_tmo_d;
   logic                  timeout_hit;

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      // NOTE: every *_d defaults to its *_q first, so no path can infer a latch.
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      pprot_d     = pprot_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      rsp_tmo_d   = rsp_tmo_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               paddr_d  = req_addr_i;
               pwrite_d = req_write_i;
               pwdata_d = req_wdata_i;
               pstrb_d  = req_write_i ? req_strb_i : '0;
               pprot_d  = req_prot_i;
               psel_d   = 1'b1;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            // PREADY takes priority over a timeout landing on the same cycle.
            if (PREADY) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               rsp_err_d   = PSLVERR;
               rsp_tmo_d   = 1'b0;
               state_d     = ST_RESP;
            end else if (timeout_hit) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_tmo_d   = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      // NOTE: reset is synchronous (sampled only on the clock edge); state uses <= only.
      if (PRESET) begin
         state_q     <= ST_IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         pprot_q     <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_tmo_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         pprot_q     <= pprot_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         rsp_tmo_q   <= rsp_tmo_d;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE) && !PRESET;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_tmo_o   = rsp_tmo_q;
   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign PSTRB       = pstrb_q;
   assign PPROT       = pprot_q;

endmodule

// File: tb/tb_apb4_requester.sv
// Bench for apb4_requester: directed scenarios plus randomized transfers, each
// checked cycle by cycle against expectations derived from the transfer rules.
module tb_apb4_requester;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 8;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic          req_valid_i, req_ready_o, req_write_i;
   logic [AW-1:0] req_addr_i;
   logic [DW-1:0] req_wdata_i;
   logic [SW-1:0] req_strb_i;
   logic [2:0]    req_prot_i;
   logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_tmo_o;
   logic [DW-1:0] rsp_rdata_o;
   logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA, PRDATA;
   logic [SW-1:0] PSTRB;
   logic [2:0]    PPROT;

   int tests_run    = 0;
   int tests_failed = 0;

   apb4_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .req_write_i(req_write_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
      .req_prot_i(req_prot_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
   );

   always #5 PCLK = ~PCLK;

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic scramble_req();
      req_addr_i  = $urandom;
      req_write_i = 1'($urandom);
      req_wdata_i = $urandom;
      req_strb_i  = SW'($urandom);
      req_prot_i  = 3'($urandom);
   endtask

   // One complete transfer; expectations follow from the transfer rules:
   // PREADY arrives on ACCESS cycle waits+1 unless the timeout ends ACCESS first.
   task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] strb, input logic [2:0] prot, input int waits,
                          input logic [DW-1:0] prdata, input logic slverr, input int rsp_delay,
                          input string tag);
      bit                 tmo_exp;
      int                 alen;
      logic [DW-1:0]      rdata_exp;
      logic               err_exp;
      logic [AW+DW+SW+3:0] apb_exp;
      logic [AW+DW+SW-1:0] hold_exp;
      tmo_exp   = (waits + 1 > TMO);
      alen      = tmo_exp ? TMO : waits + 1;
      rdata_exp = (tmo_exp || wr) ? '0 : prdata;
      err_exp   = tmo_exp ? 1'b1 : slverr;
      apb_exp   = {wr, addr, wdata, (wr ? strb : SW'(0)), prot};
      hold_exp  = {addr, wdata, (wr ? strb : SW'(0))};

      req_valid_i = 1'b1; req_addr_i = addr; req_write_i = wr;
      req_wdata_i = wdata; req_strb_i = strb; req_prot_i = prot;
      PREADY = 1'b0; rsp_ready_i = 1'b0;
      tests_run++;
      if (req_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s idle_ready: got %b exp 1", tag, req_ready_o);
      end
      step();
      req_valid_i = 1'b0;
      scramble_req();

      // Cycle 1 is SETUP, cycles 2..alen+1 are ACCESS.
      for (int c = 1; c <= alen + 1; c++) begin
         tests_run++;
         if ({PSEL, PENABLE, req_ready_o, rsp_valid_o} !== {1'b1, (c > 1), 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL %s ctrl_c%0d: got sel/en/rdy/rv %b exp %b", tag, c,
                     {PSEL, PENABLE, req_ready_o, rsp_valid_o}, {1'b1, (c > 1), 2'b00});
         end
         tests_run++;
         if ({PWRITE, PADDR, PWDATA, PSTRB, PPROT} !== apb_exp) begin
            tests_failed++;
            $display("FAIL %s apb_fields_c%0d: got %h exp %h", tag, c,
                     {PWRITE, PADDR, PWDATA, PSTRB, PPROT}, apb_exp);
         end
         PREADY  = ((c - 1) == (waits + 1));
         PRDATA  = PREADY ? prdata : $urandom;
         PSLVERR = PREADY ? slverr : 1'($urandom);
         step();
      end
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;

      // RESP, optionally back-pressured with a competing request pending.
      req_valid_i = (rsp_delay > 0);
      for (int d = 0; d <= rsp_delay; d++) begin
         tests_run++;
         if ({rsp_valid_o, rsp_err_o, rsp_tmo_o, rsp_rdata_o, PSEL, PENABLE, req_ready_o} !==
             {1'b1, err_exp, tmo_exp, rdata_exp, 3'b000}) begin
            tests_failed++;
            $display("FAIL %s resp_d%0d: got v/e/t/data/sel/en/rdy %b %b %b %h %b%b%b exp 1 %b %b %h 000",
                     tag, d, rsp_valid_o, rsp_err_o, rsp_tmo_o, rsp_rdata_o, PSEL, PENABLE,
                     req_ready_o, err_exp, tmo_exp, rdata_exp);
         end
         tests_run++;
         if ({PADDR, PWDATA, PSTRB} !== hold_exp) begin
            tests_failed++;
            $display("FAIL %s resp_hold_d%0d: got %h exp %h", tag, d, {PADDR, PWDATA, PSTRB}, hold_exp);
         end
         if (d == rsp_delay) begin
            rsp_ready_i = 1'b1;
            req_valid_i = 1'b0;
         end
         step();
      end
      rsp_ready_i = 1'b0;

      tests_run++;
      if ({rsp_valid_o, PSEL, PENABLE, req_ready_o, PADDR, PWDATA, PSTRB} !==
          {4'b0001, hold_exp}) begin
         tests_failed++;
         $display("FAIL %s back_idle: got v/sel/en/rdy %b fields %h exp 0001 %h", tag,
                  {rsp_valid_o, PSEL, PENABLE, req_ready_o}, {PADDR, PWDATA, PSTRB}, hold_exp);
      end
   endtask

   task automatic test_reset();
      PRESET = 1'b1;
      step();
      step();
      tests_run++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_valid_o, rsp_rdata_o,
           rsp_err_o, rsp_tmo_o, req_ready_o} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got sel/en/wr %b%b%b addr %h wdata %h strb %h prot %h rv %b rdata %h err %b tmo %b rdy %b exp all 0",
                  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_valid_o, rsp_rdata_o,
                  rsp_err_o, rsp_tmo_o, req_ready_o);
      end
      PRESET = 1'b0;
      #1;
      tests_run++;
      if (req_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release_ready: got %b exp 1", req_ready_o);
      end
   endtask

   task automatic test_write();
      run_txn(32'h0000_000C, 1'b1, 32'h0000_0083, 4'b0001, 3'b000, 0, 32'hDEAD_BEEF, 1'b0, 0, "write");
   endtask

   task automatic test_read_wait();
      run_txn(32'h0000_0014, 1'b0, $urandom, 4'hF, 3'b001, 3, 32'h0000_0060, 1'b0, 0, "read_wait");
   endtask

   task automatic test_slverr();
      run_txn(32'h0000_0100, 1'b1, 32'h1234_5678, 4'hA, 3'b010, 1, 32'hFFFF_FFFF, 1'b1, 0, "slverr");
   endtask

   task automatic test_timeout();
      run_txn(32'h0000_0200, 1'b0, $urandom, 4'h0, 3'b000, 1000, 32'h5555_AAAA, 1'b0, 0, "timeout");
      run_txn(32'h0000_0204, 1'b0, $urandom, 4'h0, 3'b100, TMO - 1, 32'h0000_00A5, 1'b0, 0, "ready_on_last");
      run_txn(32'h0000_0208, 1'b1, $urandom, 4'hC, 3'b011, TMO - 2, 32'h0, 1'b0, 0, "ready_before_last");
   endtask

   task automatic test_back_to_back();
      run_txn(32'h0000_0300, 1'b0, $urandom, 4'h3, 3'b101, 0, 32'hCAFE_0001, 1'b0, 5, "backpressure");
      run_txn(32'h0000_0304, 1'b1, 32'h0BAD_F00D, 4'hF, 3'b110, 0, 32'h0, 1'b0, 0, "after_backpressure");
   endtask

   task automatic test_reset_mid();
      req_valid_i = 1'b1; req_addr_i = 32'h0000_0400; req_write_i = 1'b1;
      req_wdata_i = 32'h7777_7777; req_strb_i = 4'hF; req_prot_i = 3'b000;
      PREADY = 1'b0;
      step();
      req_valid_i = 1'b0;
      step();
      step();
      tests_run++;
      if ({PSEL, PENABLE} !== 2'b11) begin
         tests_failed++;
         $display("FAIL rst_mid_in_access: got sel/en %b%b exp 11", PSEL, PENABLE);
      end
      PRESET = 1'b1;
      step();
      tests_run++;
      if ({PSEL, PENABLE, rsp_valid_o, req_ready_o, PADDR} !== '0) begin
         tests_failed++;
         $display("FAIL rst_mid_abort: got sel/en/rv/rdy %b%b%b%b addr %h exp 0000 0",
                  PSEL, PENABLE, rsp_valid_o, req_ready_o, PADDR);
      end
      PRESET = 1'b0;
      PREADY = 1'b1;
      rsp_ready_i = 1'b0;
      #1;
      tests_run++;
      if (req_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_mid_ready: got %b exp 1", req_ready_o);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if ({rsp_valid_o, PSEL, PENABLE, req_ready_o} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rst_mid_no_rsp_%0d: got v/sel/en/rdy %b exp 0001", i,
                     {rsp_valid_o, PSEL, PENABLE, req_ready_o});
         end
      end
      PREADY = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         run_txn($urandom, 1'($urandom), $urandom, SW'($urandom), 3'($urandom),
                 int'($urandom_range(0, 9)), $urandom, 1'($urandom), int'($urandom_range(0, 3)),
                 $sformatf("rand%0d", n));
      end
   endtask

   initial begin
      PRESET = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      scramble_req();
      test_reset();
      test_write();
      test_read_wait();
      test_slverr();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
